// File: rtl/cic_decimator_multi_if.sv
// Sample/config/result bundle for the multi-channel CIC decimator.
// The master drives config and input samples; the slave returns decimated results.
interface cic_decimator_multi_if #(
   parameter int CHANNELS      = 2,
   parameter int IN_WIDTH      = 32,
   parameter int MAX_RATE_LOG2 = 14
);
   localparam int RW = $clog2(MAX_RATE_LOG2 + 1);

   logic                         enable;
   logic [RW-1:0]                rate_log2;
   logic [CHANNELS*IN_WIDTH-1:0] in_data;
   logic                         in_valid;
   logic [CHANNELS*IN_WIDTH-1:0] out_data;
   logic                         out_valid;
   logic                         settling;

   modport master (
      output enable, rate_log2, in_data, in_valid,
      input  out_data, out_valid, settling
   );

   modport slave (
      input  enable, rate_log2, in_data, in_valid,
      output out_data, out_valid, settling
   );
endinterface

// File: rtl/cic_decimator_multi.sv
// N-channel, N-stage CIC decimator (M = 1) with runtime power-of-two rate,
// exact gain removal by arithmetic shift, bypass and disable modes.
module cic_decimator_multi #(
   parameter int CHANNELS      = 2,
   parameter int IN_WIDTH      = 32,
   parameter int STAGES        = 3,
   parameter int MAX_RATE_LOG2 = 14
) (
   input logic                  clock,
   input logic                  reset_n,
   cic_decimator_multi_if.slave bus
);
   localparam int AW = IN_WIDTH + STAGES * MAX_RATE_LOG2;
   localparam int RW = $clog2(MAX_RATE_LOG2 + 1);
   localparam int PW = (MAX_RATE_LOG2 > 0) ? MAX_RATE_LOG2 : 1;
   localparam int WW = $clog2(STAGES + 1);
   localparam int DW = CHANNELS * IN_WIDTH;

   function automatic logic [RW-1:0] clamp_rate(input logic [RW-1:0] r);
      if (int'(r) > MAX_RATE_LOG2) return RW'(MAX_RATE_LOG2);
      return r;
   endfunction

   // Removes the R**STAGES gain; floor semantics come from the arithmetic shift.
   function automatic logic [IN_WIDTH-1:0] normalise(input logic signed [AW-1:0] v,
                                                     input logic [RW-1:0]        r);
      logic signed [AW-1:0] s;
      s = v >>> (STAGES * int'(r));
      return s[IN_WIDTH-1:0];
   endfunction

   logic                 en_q, en_d;
   logic [RW-1:0]        rate_q, rate_d;
   logic [PW-1:0]        phase_q, rate_mask;
   logic [WW-1:0]        warm_q;
   logic                 vld_p0, vld_p1;
   logic                 out_valid_q, settling_q;
   logic [DW-1:0]        out_data_q, norm_data;
   logic signed [AW-1:0] integ_q [CHANNELS][STAGES];
   logic signed [AW-1:0] prev_q  [CHANNELS][STAGES];
   logic signed [AW-1:0] comb_q  [CHANNELS];
   logic signed [AW-1:0] diff    [CHANNELS][STAGES];
   logic                 flush, decim, accept, wrap, clear_st, warm_done;

   assign en_d      = bus.enable;
   assign rate_d    = clamp_rate(bus.rate_log2);
   assign flush     = (en_d != en_q) || (rate_d != rate_q);
   assign decim     = en_q && (rate_q != '0);
   assign accept    = decim && !flush && bus.in_valid;
   assign rate_mask = PW'((32'd1 << rate_q) - 32'd1);
   assign wrap      = accept && (phase_q == rate_mask);
   assign clear_st  = !reset_n || flush || !decim;
   assign warm_done = (warm_q == WW'(STAGES));

   // Comb chain evaluated combinationally so all stages advance on one strobe.
   always_comb begin
      logic signed [AW-1:0] acc;
      acc = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         acc = integ_q[c][STAGES-1];
         for (int k = 0; k < STAGES; k++) begin
            acc        = acc - prev_q[c][k];
            diff[c][k] = acc;
         end
      end
   end

   always_comb begin
      norm_data = '0;
      for (int c = 0; c < CHANNELS; c++)
         norm_data[c*IN_WIDTH +: IN_WIDTH] = normalise(comb_q[c], rate_q);
   end

   // p0: integrators at input rate; comb registers on the strobe.
   always_ff @(posedge clock) begin
      if (clear_st) begin
         for (int c = 0; c < CHANNELS; c++) begin
            comb_q[c] <= '0;
            for (int k = 0; k < STAGES; k++) begin
               integ_q[c][k] <= '0;
               prev_q[c][k]  <= '0;
            end
         end
      end else begin
         if (accept) begin
            for (int c = 0; c < CHANNELS; c++) begin
               integ_q[c][0] <= integ_q[c][0] + AW'($signed(bus.in_data[c*IN_WIDTH +: IN_WIDTH]));
               for (int k = 1; k < STAGES; k++)
                  integ_q[c][k] <= integ_q[c][k] + integ_q[c][k-1];
            end
         end
         if (vld_p0) begin
            for (int c = 0; c < CHANNELS; c++) begin
               prev_q[c][0] <= integ_q[c][STAGES-1];
               for (int k = 1; k < STAGES; k++)
                  prev_q[c][k] <= diff[c][k-1];
               comb_q[c] <= diff[c][STAGES-1];
            end
         end
      end
   end

   // p1 -> output: warm-up gating, normalisation and mode handling.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         en_q        <= en_d;
         rate_q      <= rate_d;
         phase_q     <= '0;
         warm_q      <= '0;
         vld_p0      <= 1'b0;
         vld_p1      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         settling_q  <= 1'b1;
      end else begin
         en_q   <= en_d;
         rate_q <= rate_d;
         if (flush) begin
            phase_q     <= '0;
            warm_q      <= '0;
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            out_valid_q <= 1'b0;
            settling_q  <= 1'b1;
         end else if (!en_q) begin
            phase_q     <= '0;
            warm_q      <= '0;
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            settling_q  <= 1'b0;
         end else if (rate_q == '0) begin
            phase_q     <= '0;
            warm_q      <= '0;
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            out_valid_q <= bus.in_valid;
            out_data_q  <= bus.in_data;
            settling_q  <= 1'b0;
         end else begin
            if (accept) phase_q <= wrap ? '0 : phase_q + 1'b1;
            vld_p0 <= wrap;
            vld_p1 <= vld_p0 && warm_done;
            if (vld_p0 && !warm_done) warm_q <= warm_q + 1'b1;
            out_valid_q <= vld_p1;
            if (vld_p1) begin
               out_data_q <= norm_data;
               settling_q <= 1'b0;
            end
         end
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.settling  = settling_q;
endmodule

// File: tb/tb_cic_decimator_multi.sv
// Randomised bench for cic_decimator_multi against a boxcar-cascade CIC reference model.
module tb_cic_decimator_multi;
   localparam int CH = 2;
   localparam int W  = 32;
   localparam int ST = 3;
   localparam int MR = 14;
   localparam int RW = $clog2(MR + 1);
   localparam int DW = CH * W;

   logic clock;
   logic reset_n;

   cic_decimator_multi_if #(.CHANNELS(CH), .IN_WIDTH(W), .MAX_RATE_LOG2(MR)) bus ();

   cic_decimator_multi #(.CHANNELS(CH), .IN_WIDTH(W), .STAGES(ST), .MAX_RATE_LOG2(MR)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      longint        due;
      logic [DW-1:0] data;
   } pend_t;

   int            n_chk;
   int            n_fail;
   longint        cyc;
   bit            data_every;
   bit            m_en;
   int            m_rate;
   int            m_cnt;
   int            m_win;
   int            xs [CH][$];
   pend_t         pend [$];
   bit            exp_v;
   bit            exp_s;
   logic [DW-1:0] exp_d;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
      end
   endtask

   function automatic longint tri_n(input longint m);
      return (m < 0) ? 64'sd0 : (m + 1) * (m + 2) / 2;
   endfunction

   // Impulse response of STAGES=3 cascaded length-R boxcars.
   function automatic longint coef(input longint k, input longint r);
      return tri_n(k) - 3 * tri_n(k - r) + 3 * tri_n(k - 2 * r) - tri_n(k - 3 * r);
   endfunction

   // Decimated output after n accepted samples; the integrator pipeline adds 2 samples of delay.
   function automatic logic [DW-1:0] cic_ref(input int n);
      logic [DW-1:0]      res;
      logic signed [95:0] acc, cw, xw, y;
      longint             r;
      int                 lo;
      r  = longint'(1) << m_rate;
      lo = n - 2 - int'(3 * r - 3);
      if (lo < 1) lo = 1;
      res = '0;
      for (int ch = 0; ch < CH; ch++) begin
         acc = '0;
         for (int i = lo; i <= n - 2; i++) begin
            cw  = coef(longint'(n - 2 - i), r);
            xw  = xs[ch][i-1];
            acc = acc + cw * xw;
         end
         y = acc >>> (ST * m_rate);
         res[ch*W +: W] = y[W-1:0];
      end
      return res;
   endfunction

   task automatic wipe();
      m_cnt = 0;
      m_win = 0;
      for (int ch = 0; ch < CH; ch++) xs[ch].delete();
      pend.delete();
   endtask

   task automatic model(input logic rn, input logic en, input logic [RW-1:0] rl,
                        input logic [DW-1:0] din, input logic vin);
      int    rc;
      pend_t p;
      rc = (int'(rl) > MR) ? MR : int'(rl);
      cyc++;
      if (!rn) begin
         m_en = en; m_rate = rc; wipe();
         exp_v = 0; exp_d = '0; exp_s = 1;
         return;
      end
      if (en != m_en || rc != m_rate) begin
         m_en = en; m_rate = rc; wipe();
         exp_v = 0; exp_s = 1;
         return;
      end
      if (!m_en) begin
         exp_v = 0; exp_d = '0; exp_s = 0;
         return;
      end
      if (m_rate == 0) begin
         exp_v = vin; exp_d = din; exp_s = 0;
         return;
      end
      exp_v = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         exp_v = 1; exp_d = pend[0].data; exp_s = 0;
         void'(pend.pop_front());
      end
      if (vin) begin
         for (int ch = 0; ch < CH; ch++) xs[ch].push_back(int'(din[ch*W +: W]));
         m_cnt++;
         if ((m_cnt % (1 << m_rate)) == 0) begin
            m_win++;
            if (m_win > ST) begin
               p.due  = cyc + 2;
               p.data = cic_ref(m_cnt);
               pend.push_back(p);
            end
         end
      end
   endtask

   task automatic step(input logic rn, input logic en, input logic [RW-1:0] rl,
                       input logic [DW-1:0] din, input logic vin);
      reset_n       = rn;
      bus.enable    = en;
      bus.rate_log2 = rl;
      bus.in_data   = din;
      bus.in_valid  = vin;
      model(rn, en, rl, din, vin);
      @(posedge clock);
      #1;
      chk("out_valid", 64'(bus.out_valid), 64'(exp_v));
      if (data_every || exp_v || bus.out_valid) chk("out_data", bus.out_data, exp_d);
      chk("settling", 64'(bus.settling), 64'(exp_s));
   endtask

   function automatic logic [DW-1:0] rnd();
      return {$urandom(), $urandom()};
   endfunction

   task automatic run_dc(input string tag);
      logic [DW-1:0] dc;
      int            hits;
      int            first;
      dc    = {32'hFFFF_FFF9, 32'd1000};
      hits  = 0;
      first = -1;
      for (int i = 0; i < 70; i++) begin
         step(1, 1, 3, dc, 1);
         if (bus.out_valid) begin
            chk({tag, "_value"}, bus.out_data, dc);
            if (first < 0) first = i;
            hits++;
         end
      end
      chk({tag, "_pulses"}, 64'(hits), 64'd5);
      chk({tag, "_first"}, 64'(first), 64'd33);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int            hits;
      logic [DW-1:0] d;
      logic [W-1:0]  alt;
      n_chk = 0; n_fail = 0; cyc = 0; data_every = 1;
      m_en = 0; m_rate = 0; exp_d = '0; exp_v = 0; exp_s = 1;
      wipe();

      repeat (3) step(0, 1, 3, rnd(), 1);
      run_dc("dc");

      for (int i = 0; i < 100; i++) step(1, 1, 3, rnd(), 1'($urandom % 2));
      repeat (3) step(0, 1, 3, rnd(), 1);
      run_dc("restart");

      for (int i = 0; i < 40; i++) begin
         d = {$urandom(), 32'h7FFF_FFFF};
         step(1, 1, 0, d, 1'($urandom % 2));
      end

      for (int i = 0; i < 20; i++) step(1, 1, 3, rnd(), 1);
      step(1, 1, 5, rnd(), 1);
      hits = 0;
      for (int i = 0; i < 164; i++) begin
         step(1, 1, 5, rnd(), 1);
         if (bus.out_valid) hits++;
      end
      chk("rate5_pulses", 64'(hits), 64'd2);

      for (int i = 0; i < 12; i++) step(1, 0, 5, rnd(), 1'($urandom % 2));
      chk("disabled_zero", bus.out_data, 64'd0);

      for (int r = 1; r <= 4; r = r * 2)
         for (int i = 0; i < 160; i++) step(1, 1, RW'(r), rnd(), 1'($urandom % 4 != 0));

      // Full-scale at the largest rate; the 14 -> 15 input change must not flush (clamped).
      data_every = 0;
      hits = 0;
      for (int i = 0; i < 65536 + 8; i++) begin
         alt = (i % 2 == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
         d   = {32'h8000_0000, alt};
         step(1, 1, (i < 30000) ? RW'(14) : RW'(15), d, 1);
         if (bus.out_valid) begin
            chk("const_fs", 64'(bus.out_data[63:32]), 64'h8000_0000);
            hits++;
         end
      end
      chk("fs_pulses", 64'(hits), 64'd1);
      data_every = 1;

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
